// File: rtl/intensity_pipe_if.sv
// Handshake bundle between the pixel-window fetch, intensity_pipe and the filter stages.
// The slave modport is the converter's view; master is the upstream/downstream view.
interface intensity_pipe_if #(
  parameter int unsigned NUM_PIX = 9,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned CNT_W   = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [3*PIX_W*NUM_PIX-1:0] pixel_data;
  logic [1:0]                 mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [PIX_W*NUM_PIX-1:0]   i_grid;
  logic [CNT_W-1:0]           grp_cnt;

  modport master (
    output in_valid, pixel_data, mode, out_ready,
    input  in_ready, out_valid, i_grid, grp_cnt
  );

  modport slave (
    input  in_valid, pixel_data, mode, out_ready,
    output in_ready, out_valid, i_grid, grp_cnt
  );
endinterface

// File: rtl/intensity_pipe.sv
// Two-stage RGB-to-intensity converter for a group of NUM_PIX pixels with four selectable
// modes, valid/ready on both sides and a count of delivered groups.
module intensity_pipe #(
  parameter int unsigned NUM_PIX = 9,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  intensity_pipe_if.slave  bus
);
  localparam int unsigned PixBits = 3 * PIX_W;
  localparam int unsigned SumW    = PIX_W + 2;
  localparam int unsigned WsumW   = 2 * PIX_W;

  logic [PIX_W-1:0] r_w    [NUM_PIX];
  logic [PIX_W-1:0] g_w    [NUM_PIX];
  logic [PIX_W-1:0] b_w    [NUM_PIX];
  logic [PIX_W-1:0] max_w  [NUM_PIX];
  logic [SumW-1:0]  sum_w  [NUM_PIX];
  logic [WsumW-1:0] wsum_w [NUM_PIX];
  logic [PIX_W-1:0] res_w  [NUM_PIX];

  logic [SumW-1:0]  sum_q  [NUM_PIX];
  logic [WsumW-1:0] wsum_q [NUM_PIX];
  logic [PIX_W-1:0] max_q  [NUM_PIX];
  logic [PIX_W-1:0] g_q    [NUM_PIX];
  logic [1:0]       mode_q;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [PIX_W*NUM_PIX-1:0] i_grid_q, i_grid_d;
  logic [CNT_W-1:0]         grp_cnt_q, grp_cnt_d;
  logic                     s1_adv, in_ready, accept, s2_load, out_xfer;

  // Stage-1 arithmetic; pixel 0 sits in the MSBs, each pixel packed {R,G,B}.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PIX; i++) begin
      r_w[i]    = bus.pixel_data[(NUM_PIX-1-i)*PixBits + 2*PIX_W +: PIX_W];
      g_w[i]    = bus.pixel_data[(NUM_PIX-1-i)*PixBits + PIX_W +: PIX_W];
      b_w[i]    = bus.pixel_data[(NUM_PIX-1-i)*PixBits +: PIX_W];
      sum_w[i]  = SumW'(r_w[i]) + SumW'(g_w[i]) + SumW'(b_w[i]);
      wsum_w[i] = WsumW'(77) * WsumW'(r_w[i]) + WsumW'(150) * WsumW'(g_w[i])
                + WsumW'(29) * WsumW'(b_w[i]);
      max_w[i]  = (r_w[i] >= g_w[i]) ? r_w[i] : g_w[i];
      max_w[i]  = (max_w[i] >= b_w[i]) ? max_w[i] : b_w[i];
    end
  end

  // Stage-2 result select; the weights sum to 256 so the luma shift never overflows.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PIX; i++) begin
      case (mode_q)
        2'd0:    res_w[i] = PIX_W'(sum_q[i] / SumW'(3));
        2'd1:    res_w[i] = PIX_W'(wsum_q[i] >> PIX_W);
        2'd2:    res_w[i] = max_q[i];
        default: res_w[i] = g_q[i];
      endcase
    end
  end

  always_comb begin
    s1_adv     = !s2_valid_q || bus.out_ready;
    in_ready   = !s1_valid_q || s1_adv;
    accept     = bus.in_valid && in_ready;
    s2_load    = s1_valid_q && s1_adv;
    out_xfer   = s2_valid_q && bus.out_ready;

    s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    grp_cnt_d  = grp_cnt_q + CNT_W'(out_xfer);

    i_grid_d   = i_grid_q;
    if (s2_load) begin
      for (int unsigned i = 0; i < NUM_PIX; i++) begin
        i_grid_d[(NUM_PIX-1-i)*PIX_W +: PIX_W] = res_w[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      i_grid_q   <= '0;
      grp_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      i_grid_q   <= i_grid_d;
      grp_cnt_q  <= grp_cnt_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < NUM_PIX; i++) begin
        sum_q[i]  <= sum_w[i];
        wsum_q[i] <= wsum_w[i];
        max_q[i]  <= max_w[i];
        g_q[i]    <= g_w[i];
      end
      mode_q <= bus.mode;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.i_grid    = i_grid_q;
  assign bus.grp_cnt   = grp_cnt_q;
endmodule
